bn_mul_serial: RTL
==================

Name: bn_mul_serial

Overview:
- Parametrised, multi-cycle big-number multiplier using product scanning. Each cycle it performs one LIMB_W x LIMB_W multiply-accumulate.
- Computes the full, unreduced 2*N_LIMBS*LIMB_W-bit product of two N_LIMBS*LIMB_W-bit operands.
- Adds a start/busy/done handshake and operand latching, so it can sit under a control FSM next to the modular-reduction and point-arithmetic blocks.

Parameters:
- N_LIMBS, 8, number of limbs per operand (>=2).
- LIMB_W, 32, bits per limb; operand width OP_W = N_LIMBS*LIMB_W.
- ACC_W, 2*LIMB_W + $clog2(N_LIMBS) + 1, internal accumulator width.

Ports:
- clk  in  1  rising-edge clock
- reset_n  in  1  asynchronous active-low reset
- rx_start  in  1  request a multiply; accepted only when tx_busy==0
- rx_a  in  OP_W  operand A; sampled only on the accept edge
- rx_b  in  OP_W  operand B; sampled only on the accept edge
- tx_busy  out  1  high while a multiply is in progress
- tx_done  out  1  high from completion until the next accepted start
- tx_r  out  2*OP_W  product A*B; valid while tx_done==1

Behaviour:
- Reset (reset_n low, asynchronous): tx_busy=0, tx_done=0, tx_r=0, accumulator=0, all indices (k, i, j)=0, state=IDLE. Reset during MUL aborts the operation; no partial result is kept.
- States: IDLE and MUL.
- IDLE -> MUL: on a clk edge with rx_start=1.
  - Latch rx_a and rx_b into internal registers.
  - Clear tx_r, tx_done and the accumulator.
  - Set k=0, i=0, j=0, tx_busy=1.
- rx_start while tx_busy=1 is ignored. Changes to rx_a/rx_b after the accept edge have no effect.
- MUL, each cycle:
  - new_acc = acc + A[i]*B[j], where X[n] = limb n of the latched operand.
  - Column k is the set of pairs with i+j=k, walked with i ascending and j descending.
  - Column k is finished when i==N_LIMBS-1 or i==k.
- End of column k:
  - tx_r limb k <= new_acc[LIMB_W-1:0].
  - acc <= new_acc >> LIMB_W.
  - Next column starts at i=0, j=k+1 if k+1 <= N_LIMBS-1; otherwise at i=k+2-N_LIMBS, j=N_LIMBS-1.
- Otherwise (mid-column): acc <= new_acc, i++, j--.
- Final column k=2*N_LIMBS-2:
  - Also write tx_r limb 2*N_LIMBS-1 <= new_acc[2*LIMB_W-1:LIMB_W].
  - Set tx_done=1, tx_busy=0, state=IDLE.
- Latency: exactly N_LIMBS^2 clk edges from the accept edge to the edge that raises tx_done (64 for the defaults).
- tx_done and tx_r hold until the next accepted start. A start on the first edge after tx_done rises is accepted, so back-to-back throughput is one result per N_LIMBS^2+1 cycles at most.
- Arithmetic and width rules:
  - Accumulator never overflows ACC_W.
  - The final carry fits in the top limb; the product is exact.
  - No modular reduction is performed.
- Index registers are sized $clog2(N_LIMBS) bits for i and j, and $clog2(2*N_LIMBS) bits for k.
- The design must not rely on index wrap-around for non-power-of-two N_LIMBS.

Test Plan:
- Zero operand: defaults, A=0, B=0x1234_5678 -> after 64 cycles tx_done=1, tx_r=0, tx_busy=0.
- Maximum operands: A=B=2^256-1 -> tx_r = 2^512-2^257+1, i.e. top limb 0xFFFFFFFF, limb 4..7 pattern per model, limb0=0x00000001. Confirms carry propagation into limb 15.
- Latency and handshake:
  - Pulse rx_start at edge E0 -> tx_busy=1 from E0 through E63, tx_done rises exactly at E64.
  - Change rx_a/rx_b at E1 -> result unchanged.
  - Pulse rx_start at E10 -> ignored.
- Reset mid-operation: deassert reset_n asynchronously at E30 -> outputs go to zero immediately without waiting for clk. Release reset, then start A=3, B=5 -> tx_r=15 after 64 cycles.
- Back-to-back: start again on the first edge after tx_done -> tx_done clears on that edge and the second product is correct. Also check that tx_r was cleared at the accept edge.
- Parameter sweep: N_LIMBS=3 and N_LIMBS=5 with LIMB_W=16; 1000 random operand pairs each -> tx_r equals the reference A*B, and latency equals 9 and 25 cycles respectively.

Source files
------------

// File: rtl/bn_mul_serial.sv
// Serial product-scanning big-number multiplier: one LIMB_W x LIMB_W MAC per cycle,
// full 2*OP_W-bit result, start/busy/done handshake with operand latching.
module bn_mul_serial #(
  parameter int unsigned N_LIMBS = 8,
  parameter int unsigned LIMB_W  = 32,
  parameter int unsigned ACC_W   = 2*LIMB_W + $clog2(N_LIMBS) + 1
) (
  input  logic                          clk,
  input  logic                          reset_n,
  input  logic                          rx_start,
  input  logic [N_LIMBS*LIMB_W-1:0]     rx_a,
  input  logic [N_LIMBS*LIMB_W-1:0]     rx_b,
  output logic                          tx_busy,
  output logic                          tx_done,
  output logic [2*N_LIMBS*LIMB_W-1:0]   tx_r
);

  localparam int unsigned OP_W = N_LIMBS * LIMB_W;
  localparam int unsigned PW   = 2 * LIMB_W;
  localparam int unsigned IW   = $clog2(N_LIMBS);
  localparam int unsigned KW   = $clog2(2 * N_LIMBS);
  localparam int unsigned RL   = 2 * N_LIMBS;

  typedef enum logic {S_IDLE, S_MUL} state_t;

  state_t            state_q, state_d;
  logic [OP_W-1:0]   a_q, a_d, b_q, b_d;
  logic [ACC_W-1:0]  acc_q, acc_d;
  logic [IW-1:0]     i_q, i_d, j_q, j_d;
  logic [KW-1:0]     k_q, k_d;
  logic [LIMB_W-1:0] r_q [RL];
  logic [LIMB_W-1:0] r_d [RL];
  logic              busy_q, busy_d, done_q, done_d;

  logic [LIMB_W-1:0] a_limb [N_LIMBS];
  logic [LIMB_W-1:0] b_limb [N_LIMBS];
  logic [PW-1:0]     prod_c;
  logic [ACC_W-1:0]  new_acc_c;
  logic              col_end_c, last_col_c;

  for (genvar g = 0; g < N_LIMBS; g++) begin : g_op
    assign a_limb[g] = a_q[g*LIMB_W +: LIMB_W];
    assign b_limb[g] = b_q[g*LIMB_W +: LIMB_W];
  end

  for (genvar g = 0; g < RL; g++) begin : g_res
    assign tx_r[g*LIMB_W +: LIMB_W] = r_q[g];
  end

  assign tx_busy = busy_q;
  assign tx_done = done_q;

  // Datapath: one limb product folded into the column accumulator
  assign prod_c     = PW'(a_limb[i_q]) * PW'(b_limb[j_q]);
  assign new_acc_c  = acc_q + ACC_W'(prod_c);
  assign col_end_c  = (i_q == IW'(N_LIMBS - 1)) || (KW'(i_q) == k_q);
  assign last_col_c = (k_q == KW'(2*N_LIMBS - 2));

  // Next-state and register updates
  always_comb begin
    state_d = state_q;
    a_d     = a_q;
    b_d     = b_q;
    acc_d   = acc_q;
    i_d     = i_q;
    j_d     = j_q;
    k_d     = k_q;
    r_d     = r_q;
    busy_d  = busy_q;
    done_d  = done_q;
    case (state_q)
      S_IDLE: begin
        if (rx_start) begin
          a_d    = rx_a;
          b_d    = rx_b;
          acc_d  = '0;
          i_d    = '0;
          j_d    = '0;
          k_d    = '0;
          busy_d = 1'b1;
          done_d = 1'b0;
          for (int n = 0; n < int'(RL); n++) r_d[n] = '0;
          state_d = S_MUL;
        end
      end
      S_MUL: begin
        if (col_end_c) begin
          r_d[k_q] = new_acc_c[LIMB_W-1:0];
          acc_d    = new_acc_c >> LIMB_W;
          if (last_col_c) begin
            r_d[RL-1] = new_acc_c[PW-1:LIMB_W];
            busy_d    = 1'b0;
            done_d    = 1'b1;
            i_d       = '0;
            j_d       = '0;
            k_d       = '0;
            state_d   = S_IDLE;
          end else begin
            k_d = k_q + KW'(1);
            // Lower half of the columns starts at i=0; upper half is clipped by j=N-1
            if (k_q < KW'(N_LIMBS - 1)) begin
              i_d = '0;
              j_d = IW'(k_q + KW'(1));
            end else begin
              i_d = IW'(k_q + KW'(2) - KW'(N_LIMBS));
              j_d = IW'(N_LIMBS - 1);
            end
          end
        end else begin
          acc_d = new_acc_c;
          i_d   = i_q + IW'(1);
          j_d   = j_q - IW'(1);
        end
      end
    endcase
  end

  // State and datapath registers
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= S_IDLE;
      a_q     <= '0;
      b_q     <= '0;
      acc_q   <= '0;
      i_q     <= '0;
      j_q     <= '0;
      k_q     <= '0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      for (int n = 0; n < int'(RL); n++) r_q[n] <= '0;
    end else begin
      state_q <= state_d;
      a_q     <= a_d;
      b_q     <= b_d;
      acc_q   <= acc_d;
      i_q     <= i_d;
      j_q     <= j_d;
      k_q     <= k_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
      r_q     <= r_d;
    end
  end

endmodule
